// File: rtl/cnn_pkg.sv
// Shared types and constants for the convolution read path.
package cnn_pkg;

  localparam int unsigned KERNEL     = 3;
  localparam int unsigned STRIDE_MIN = 1;
  localparam int unsigned STRIDE_MAX = 2;
  localparam int unsigned DIM_W      = 12;
  localparam int unsigned STRIDE_W   = 2;
  // Window-end comparisons are done two bits wider so pos+KERNEL+stride never wraps.
  localparam int unsigned CMP_W      = 14;
  localparam int unsigned WIN_CNT_W  = 24;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StDrain,
    StDone
  } rd_state_e;

  typedef struct packed {
    logic valid;
    logic last;
    logic chlast;
  } rd_tag_t;

  // A config the read sequencer cannot walk: too narrow, no channels, or bad stride.
  function automatic logic cfg_bad(input logic [DIM_W-1:0]    width,
                                   input logic [DIM_W-1:0]    channel,
                                   input logic [STRIDE_W-1:0] stride);
    return (width < DIM_W'(KERNEL)) || (channel == '0) ||
           (stride < STRIDE_W'(STRIDE_MIN)) || (stride > STRIDE_W'(STRIDE_MAX));
  endfunction

  // True when the next step along this dimension would push the kernel past the edge.
  function automatic logic dim_end(input logic [DIM_W-1:0]    pos,
                                   input logic [DIM_W-1:0]    dim,
                                   input logic [STRIDE_W-1:0] stride);
    logic [CMP_W-1:0] reach;
    reach = CMP_W'(pos) + CMP_W'(KERNEL) + CMP_W'(stride);
    return CMP_W'(dim) < reach;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Delays each issued window's tag by the BRAM read latency so the flags line up with the data.
module rd_tag_pipe
  import cnn_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic last,
  input  logic chlast,
  output logic push,
  output logic push_last,
  output logic push_chlast,
  output logic empty
);

  rd_tag_t [RD_LAT-1:0] pipe_q;

  // Shift register of tags; a reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      pipe_q[0] <= '{valid: load, last: load & last, chlast: load & chlast};
    end
  end

  // Empty when no stage holds a valid tag.
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pipe_q[i].valid) begin
        empty = 1'b0;
      end
    end
  end

  // The oldest stage is the one whose data is on the BRAM output now.
  always_comb begin
    push        = pipe_q[RD_LAT-1].valid;
    push_last   = pipe_q[RD_LAT-1].last;
    push_chlast = pipe_q[RD_LAT-1].chlast;
  end

endmodule

// File: rtl/conv_rd_sched.sv
// Read sequencer for one 3x3 convolution input pass: walks col/row/channel in step with the
// address generator, throttles on downstream FIFO credits and tags returning reads.
module conv_rd_sched
  import cnn_pkg::*;
#(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = WIN_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DIM_W-1:0]    cfg_width,
  input  logic [DIM_W-1:0]    cfg_channel,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic                fifo_pop,
  output logic                gen_rst,
  output logic                addr_inc,
  output logic                bram_en,
  output logic                push,
  output logic                push_last,
  output logic                push_chlast,
  output logic                busy,
  output logic                done,
  output logic                err_cfg,
  output logic [CNT_W-1:0]    win_cnt
);

  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);

  rd_state_e             state_q, state_d;
  logic [DIM_W-1:0]      width_q, channel_q;
  logic [STRIDE_W-1:0]   stride_q;
  logic [DIM_W-1:0]      col_q, row_q, ch_q;
  logic [CRED_W-1:0]     credit_q, credit_d;
  logic [CNT_W-1:0]      win_cnt_q;
  logic                  err_q;

  logic issue;
  logic col_end, row_end, ch_end;
  logic win_chlast, pass_last;
  logic pop_ok;
  logic pipe_empty;
  logic cfg_reject;

  always_comb begin
    issue      = (state_q == StIssue) && (credit_q != '0);
    col_end    = dim_end(col_q, width_q, stride_q);
    row_end    = dim_end(row_q, width_q, stride_q);
    ch_end     = (ch_q == channel_q - DIM_W'(1));
    win_chlast = col_end & row_end;
    pass_last  = win_chlast & ch_end;
    cfg_reject = cfg_bad(width_q, channel_q, stride_q);
    // A returned credit with nothing outstanding has nowhere to go.
    pop_ok     = fifo_pop && (credit_q != CRED_W'(FIFO_DEPTH));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = cfg_reject ? StDone : StIssue;
      StIssue: if (issue && pass_last) state_d = StDrain;
      StDrain: if (pipe_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    gen_rst  = rst | (state_q == StLoad);
    addr_inc = issue;
    bram_en  = issue;
    busy     = (state_q == StLoad) || (state_q == StIssue) || (state_q == StDrain);
    done     = (state_q == StDone);
  end

  // Config latch, error flag and saturating issue counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q   <= '0;
      channel_q <= '0;
      stride_q  <= '0;
      err_q     <= 1'b0;
      win_cnt_q <= '0;
    end else begin
      if ((state_q == StIdle) && start) begin
        width_q   <= cfg_width;
        channel_q <= cfg_channel;
        stride_q  <= cfg_stride;
        err_q     <= 1'b0;
        win_cnt_q <= '0;
      end
      if ((state_q == StLoad) && cfg_reject) begin
        err_q <= 1'b1;
      end
      if (issue && (win_cnt_q != '1)) begin
        win_cnt_q <= win_cnt_q + CNT_W'(1);
      end
    end
  end

  // Window position counters, shadowing the address generator step for step.
  always_ff @(posedge clk) begin
    if (rst || (state_q == StLoad)) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else if (issue) begin
      col_q <= col_end ? '0 : col_q + DIM_W'(stride_q);
      if (col_end) begin
        row_q <= row_end ? '0 : row_q + DIM_W'(stride_q);
        if (row_end) begin
          ch_q <= ch_q + DIM_W'(1);
        end
      end
    end
  end

  // Credit next value: issue and accepted pop in the same cycle cancel out.
  always_comb begin
    credit_d = credit_q;
    case ({issue, pop_ok})
      2'b10:   credit_d = credit_q - CRED_W'(1);
      2'b01:   credit_d = credit_q + CRED_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  // Credit register, persisting across passes since the FIFO does.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CRED_W'(FIFO_DEPTH);
    end else begin
      credit_q <= credit_d;
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .load        (issue),
    .last        (pass_last),
    .chlast      (win_chlast),
    .push        (push),
    .push_last   (push_last),
    .push_chlast (push_chlast),
    .empty       (pipe_empty)
  );

  assign err_cfg = err_q;
  assign win_cnt = win_cnt_q;

endmodule

// File: tb/tb_conv_rd_sched.sv
// Bench for conv_rd_sched: directed and randomized passes against a window-list model.
module tb_conv_rd_sched;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [11:0]       cfg_width;
  logic [11:0]       cfg_channel;
  logic [1:0]        cfg_stride;
  logic              fifo_pop;
  logic              gen_rst, addr_inc, bram_en, push, push_last, push_chlast;
  logic              busy, done, err_cfg;
  logic [CNT_W-1:0]  win_cnt;

  always #5 clk = ~clk;

  conv_rd_sched #(
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_width   (cfg_width),
    .cfg_channel (cfg_channel),
    .cfg_stride  (cfg_stride),
    .fifo_pop    (fifo_pop),
    .gen_rst     (gen_rst),
    .addr_inc    (addr_inc),
    .bram_en     (bram_en),
    .push        (push),
    .push_last   (push_last),
    .push_chlast (push_chlast),
    .busy        (busy),
    .done        (done),
    .err_cfg     (err_cfg),
    .win_cnt     (win_cnt)
  );

  typedef struct {
    int t;
    bit last;
    bit chlast;
  } exp_t;

  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   credits_m = DEPTH;
  int   issued_m = 0;
  int   total_m = 0;
  int   n2_m = 1;
  bit   err_m = 1'b0;
  int   done_cnt = 0;
  int   pop_mode = 0;    // 0 none, 1 pop whenever a window arrives, 2 random
  bit   pop_force = 1'b0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Windows in a pass: positions per side times itself times channels, or none if rejected.
  function automatic bit model_bad(input int w, input int s, input int c);
    return (w < 3) || (c == 0) || (s < 1) || (s > 2);
  endfunction

  function automatic int model_side(input int w, input int s);
    return (w - 3) / s + 1;
  endfunction

  // Per-cycle reference check, sampled mid-cycle.
  task automatic monitor();
    exp_t e;
    bit   exp_issue;
    bit   pop_ok;
    int   side;
    cyc++;
    if (rst) begin
      credits_m = DEPTH;
      exp_q.delete();
      issued_m = 0;
      total_m  = 0;
      err_m    = 1'b0;
    end else begin
      if (exp_q.size() != 0 && exp_q[0].t == cyc) begin
        e = exp_q.pop_front();
        chk("push", 32'(push), 32'd1);
        chk("push_last", 32'(push_last), 32'(e.last));
        chk("push_chlast", 32'(push_chlast), 32'(e.chlast));
      end else begin
        chk("no_push", 32'(push), 32'd0);
      end
      // Once loaded, a pass issues every cycle it holds a credit until all windows are out.
      exp_issue = busy && !gen_rst && (issued_m < total_m) && (credits_m > 0);
      chk("bram_en", 32'(bram_en), 32'(exp_issue));
      chk("addr_inc", 32'(addr_inc), 32'(exp_issue));
      if (bram_en === 1'b1) begin
        e.t      = cyc + RD_LAT;
        e.last   = (issued_m + 1 == total_m);
        e.chlast = ((issued_m + 1) % n2_m == 0);
        exp_q.push_back(e);
        issued_m++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        chk("win_cnt", 32'(win_cnt), 32'(total_m));
        chk("err_cfg", 32'(err_cfg), 32'(err_m));
        chk("issue_total", 32'(issued_m), 32'(total_m));
      end
      pop_ok    = fifo_pop && (credits_m < DEPTH);
      credits_m = credits_m + int'(pop_ok) - int'(bram_en === 1'b1);
      if (start && !busy && !done) begin
        err_m    = model_bad(int'(cfg_width), int'(cfg_stride), int'(cfg_channel));
        issued_m = 0;
        if (err_m) begin
          total_m = 0;
          n2_m    = 1;
        end else begin
          side    = model_side(int'(cfg_width), int'(cfg_stride));
          n2_m    = side * side;
          total_m = n2_m * int'(cfg_channel);
        end
      end
    end
  endtask

  // One clock: check mid-cycle, then drive the consumer just after the edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    fifo_pop = pop_force || (pop_mode == 1 && push === 1'b1) ||
               (pop_mode == 2 && $urandom_range(0, 1) == 1);
  endtask

  task automatic pulse_start(input int w, input int s, input int c);
    cfg_width   = 12'(w);
    cfg_stride  = 2'(s);
    cfg_channel = 12'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_pass(input string tag, input int d0);
    int n = 0;
    bit seen = 1'b0;
    while (n < 3000 && !seen) begin
      tick();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) tick();
    chk({tag, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_pass(input string tag, input int w, input int s, input int c);
    int d0;
    d0 = done_cnt;
    pulse_start(w, s, c);
    finish_pass(tag, d0);
  endtask

  initial begin
    int d0;
    int w, s, c;
    rst = 1'b1;
    start = 1'b0;
    fifo_pop = 1'b0;
    cfg_width = '0;
    cfg_channel = '0;
    cfg_stride = '0;
    repeat (3) tick();
    chk("rst_gen_rst", 32'(gen_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bram_en", 32'(bram_en), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_cfg), 32'd0);
    chk("rst_win_cnt", 32'(win_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_gen_rst", 32'(gen_rst), 32'd0);

    // Basic passes with a consumer that drains every arriving window.
    pop_mode = 1;
    run_pass("w5s1c1", 5, 1, 1);
    chk("w5s1c1_count", 32'(issued_m), 32'd9);
    run_pass("w6s2c2", 6, 2, 2);
    chk("w6s2c2_count", 32'(issued_m), 32'd8);

    // Rejected configs, then a good pass that must clear the error.
    run_pass("bad_w2", 2, 1, 1);
    run_pass("bad_s0", 5, 0, 1);
    run_pass("bad_c0", 5, 1, 0);
    run_pass("bad_s3", 5, 3, 1);
    run_pass("good_after_bad", 4, 1, 3);

    // Credit starvation: no consumer.
    pop_mode = 0;
    d0 = done_cnt;
    pulse_start(5, 1, 1);
    repeat (20) tick();
    chk("stall_issues", 32'(issued_m), 32'd4);
    for (int i = 0; i < 2; i++) begin
      pop_force = 1'b1;
      tick();
      pop_force = 1'b0;
      repeat (5) tick();
      chk("single_pop_issue", 32'(issued_m), 32'(5 + i));
    end
    // Held pop: issues at credit 1 alongside a pop must keep flowing.
    pop_force = 1'b1;
    repeat (3) tick();
    pop_force = 1'b0;
    finish_pass("stall", d0);
    chk("stall_total", 32'(issued_m), 32'd9);
    pop_force = 1'b1;
    repeat (6) tick();
    pop_force = 1'b0;
    tick();

    // start while busy is ignored.
    pop_mode = 1;
    d0 = done_cnt;
    pulse_start(6, 1, 1);
    repeat (4) tick();
    pulse_start(3, 2, 3);
    finish_pass("start_busy", d0);
    chk("start_busy_count", 32'(issued_m), 32'd16);

    // Reset in the middle of issuing.
    pulse_start(7, 1, 2);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_gen_rst", 32'(gen_rst), 32'd1);
    chk("midrst_push", 32'(push), 32'd0);
    chk("midrst_bram_en", 32'(bram_en), 32'd0);
    chk("midrst_win_cnt", 32'(win_cnt), 32'd0);
    rst = 1'b0;
    repeat (RD_LAT + 3) tick();
    run_pass("after_rst", 5, 2, 2);

    // Randomized passes with a random consumer.
    pop_mode = 2;
    for (int r = 0; r < 8; r++) begin
      w = int'($urandom_range(3, 10));
      s = int'($urandom_range(1, 2));
      c = int'($urandom_range(1, 3));
      if (r == 5) s = 3;
      run_pass("rand", w, s, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
